case_bist_ctrl: RTL and testbench

Self-test sequencer that sits on the far side of a 4-input/2-output combinational benchmark circuit such as the synthesized case netlists. It drives the circuit inputs a, b, c and d with every input pattern. It compacts the returned outputs y1 and y2 into a MISR signature and reports pass/fail against a golden signature. Synthesized netlists are verified on-chip against their RTL this way.

---
 rtl/case_bist_ctrl.sv | 117 +++++++++++
 tb/tb_case_bist_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/case_bist_ctrl.sv
// Exhaustive-pattern BIST sequencer: sweeps {a,b,c,d} through every input
// pattern, compacts {y1,y2} into a MISR and compares the result to GOLDEN.
module case_bist_ctrl #(
  parameter int unsigned      NUM_IN = 4,
  parameter int unsigned      SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = 16'h002D,
  parameter logic [SIG_W-1:0] GOLDEN = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  input  logic             y1,
  input  logic             y2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [NUM_IN-1:0] PAT_LAST = '1;

  state_e            state_q, state_d;
  logic [NUM_IN-1:0] pat_q, pat_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [SIG_W-1:0]  sig_step;
  logic              pass_q, pass_d;
  logic [NUM_IN-1:0] drive;

  // The response is combinational, so it is folded in the same cycle pat is driven.
  always_comb begin
    sig_step = {sig_q[SIG_W-2:0], 1'b0}
             ^ (sig_q[SIG_W-1] ? POLY : '0)
             ^ {{(SIG_W-2){1'b0}}, y1, y2};
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        pass_d = 1'b0;
        if (start) begin
          state_d = RUN;
          pat_d   = '0;
          sig_d   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          pat_d   = '0;
          sig_d   = '0;
          pass_d  = 1'b0;
        end else begin
          sig_d = sig_step;
          if (pat_q == PAT_LAST) begin
            state_d = DONE;
            pat_d   = '0;
            pass_d  = (sig_step == GOLDEN);
          end else begin
            pat_d = pat_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          pat_d   = '0;
          sig_d   = '0;
          pass_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        pat_d   = '0;
        sig_d   = '0;
        pass_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      sig_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    drive     = (state_q == RUN) ? pat_q : '0;
    a         = drive[NUM_IN-1];
    b         = drive[NUM_IN-2];
    c         = drive[NUM_IN-3];
    d         = drive[0];
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    pass      = pass_q;
    signature = sig_q;
  end

endmodule

// File: tb/tb_case_bist_ctrl.sv
// Scoreboard bench for case_bist_ctrl: runs push expected signatures, a
// negedge monitor checks the pattern sweep and pops results on done.
module tb_case_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic        a, b, c, d, y1, y2, busy, done, pass;
  logic [15:0] signature;
  logic        a_g, b_g, c_g, d_g, busy_g, done_g, pass_g;
  logic [15:0] signature_g;

  logic [31:0] resp_bits = '0;
  logic [3:0]  pat_idx;

  typedef struct {
    logic [15:0] sig;
    logic        pass0;
    logic        passg;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  case_bist_ctrl #(.NUM_IN(4), .SIG_W(16), .POLY(16'h002D), .GOLDEN(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a(a), .b(b), .c(c), .d(d), .y1(y1), .y2(y2),
    .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  case_bist_ctrl #(.NUM_IN(4), .SIG_W(16), .POLY(16'h002D), .GOLDEN(16'h8000)) dut_g (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a(a_g), .b(b_g), .c(c_g), .d(d_g), .y1(y1), .y2(y2),
    .busy(busy_g), .done(done_g), .pass(pass_g), .signature(signature_g)
  );

  // Emulated circuit under test: response per pattern comes from a table.
  assign pat_idx  = {a, b, c, d};
  assign {y1, y2} = busy ? resp_bits[{pat_idx, 1'b0} +: 2] : 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signature as the remainder of the response stream polynomial modulo
  // x^16+x^5+x^3+x^2+1, with pattern 0 entering first.
  function automatic logic [15:0] model_sig(input logic [31:0] r);
    int unsigned s;
    s = 0;
    for (int p = 0; p < 16; p++) begin
      s = s * 2;
      if (s >= 32'h10000) s = s ^ 32'h1002D;
      s = s ^ ((r >> (2 * p)) & 32'h3);
    end
    return 16'(s);
  endfunction

  int   exp_pat   = 0;
  int   busy_cnt  = 0;
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) begin
      check("pattern", {28'd0, pat_idx}, exp_pat[31:0]);
      check("pattern_g", {28'd0, a_g, b_g, c_g, d_g}, exp_pat[31:0]);
      exp_pat++;
      busy_cnt++;
    end else begin
      exp_pat = 0;
      if (done !== 1'b1) busy_cnt = 0;
    end
    if (done === 1'b1 && !done_prev) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("signature", {16'd0, signature}, {16'd0, e.sig});
        check("pass", {31'd0, pass}, {31'd0, e.pass0});
        check("signature_g", {16'd0, signature_g}, {16'd0, e.sig});
        check("pass_g", {31'd0, pass_g}, {31'd0, e.passg});
        check("busy_cycles", busy_cnt, 32'd16);
      end
      busy_cnt = 0;
    end
    done_prev = (done === 1'b1);
  end

  task automatic check_idle(input string name);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_done"}, {31'd0, done}, 32'd0);
    check({name, "_pass"}, {31'd0, pass}, 32'd0);
    check({name, "_sig"}, {16'd0, signature}, 32'd0);
    check({name, "_abcd"}, {28'd0, pat_idx}, 32'd0);
  endtask

  task automatic wait_pattern(input int n);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b1 && pat_idx == 4'(n)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("pattern_timeout", {31'd0, found}, 32'd1);
  endtask

  task automatic run_case(input logic [31:0] resp, input logic [15:0] exp, input int hold);
    exp_t e;
    resp_bits = resp;
    e.sig     = exp;
    e.pass0   = (exp == 16'h0000);
    e.passg   = (exp == 16'h8000);
    q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_done", {31'd0, done}, 32'd0);
    check("start_pass", {31'd0, pass}, 32'd0);
    repeat (hold - 1) @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    check("done_timeout", {31'd0, done}, 32'd1);
    check("done_abcd", {28'd0, pat_idx}, 32'd0);
    check("done_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("done_hold", {31'd0, done}, 32'd1);
    check("sig_hold", {16'd0, signature}, {16'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("idle");

    run_case(32'h0000_0000, 16'h0000, 1);
    run_case(32'h4000_0000, 16'h0001, 1);
    run_case(32'h1000_0000, 16'h0002, 1);
    run_case(32'h0000_0001, 16'h8000, 1);
    run_case(32'h0000_0002, 16'h002D, 1);
    run_case(32'h0000_0001, 16'h8000, 1);
    run_case(32'h0000_0000, 16'h0000, 1);

    // start held for several RUN cycles must not restart the sweep
    run_case(32'h0000_0000, 16'h0000, 5);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_pattern(7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort");

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_pattern(15);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check_idle("abort_start");
    @(negedge clk);
    check_idle("abort_start_after");

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort_in_idle");

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_pattern(9);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("reset_mid_run");

    for (int k = 0; k < 12; k++) begin
      r = $urandom();
      run_case(r, model_sig(r), int'($urandom_range(1, 4)));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
